// File: rtl/rob_commit.sv
// rob_commit: in-order dual-allocate, dual-writeback, dual-retire reorder buffer
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   flush                       squash every entry on the next edge
//   alloc_N_valid/has_rd/rd     rename-side allocation requests (slot 0 older)
//   alloc_ready, alloc_N_tag    at least two free entries; tags handed to rename
//   wb_N_valid/tag/data         writeback buses
//   commit_N_retire/we/addr/data/tag  in-order retirement to the register file
//   rob_count, rob_empty        occupancy
// Optional feature: define ROB_WB_BYPASS_EN to let a same-cycle writeback make
// the head candidates retire immediately with the bus data.
module rob_commit #(
   parameter int ROB_DEPTH = 32,
   parameter int TAG_WIDTH = $clog2(ROB_DEPTH),
   parameter int DATA_W    = 32,
   parameter int AREG_W    = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 alloc_0_valid,
   input  logic                 alloc_1_valid,
   input  logic                 alloc_0_has_rd,
   input  logic                 alloc_1_has_rd,
   input  logic [AREG_W-1:0]    alloc_0_rd,
   input  logic [AREG_W-1:0]    alloc_1_rd,
   output logic                 alloc_ready,
   output logic [TAG_WIDTH-1:0] alloc_0_tag,
   output logic [TAG_WIDTH-1:0] alloc_1_tag,
   input  logic                 wb_0_valid,
   input  logic                 wb_1_valid,
   input  logic [TAG_WIDTH-1:0] wb_0_tag,
   input  logic [TAG_WIDTH-1:0] wb_1_tag,
   input  logic [DATA_W-1:0]    wb_0_data,
   input  logic [DATA_W-1:0]    wb_1_data,
   output logic                 commit_0_retire,
   output logic                 commit_1_retire,
   output logic                 commit_0_we,
   output logic                 commit_1_we,
   output logic [AREG_W-1:0]    commit_0_addr,
   output logic [AREG_W-1:0]    commit_1_addr,
   output logic [DATA_W-1:0]    commit_0_data,
   output logic [DATA_W-1:0]    commit_1_data,
   output logic [TAG_WIDTH-1:0] commit_0_tag,
   output logic [TAG_WIDTH-1:0] commit_1_tag,
   output logic [TAG_WIDTH:0]   rob_count,
   output logic                 rob_empty
);
   localparam logic [TAG_WIDTH:0] CMAX = (TAG_WIDTH+1)'(ROB_DEPTH - 2);
   logic [TAG_WIDTH-1:0] head, tail, h1, t1;
   logic [TAG_WIDTH:0]   count, na, nr;
   logic [ROB_DEPTH-1:0] valid, ready, has_rd;
   logic [AREG_W-1:0]    rd_q   [ROB_DEPTH];
   logic [DATA_W-1:0]    data_q [ROB_DEPTH];
   logic                 a0, a1, b0, b1;
   logic [DATA_W-1:0]    d0, d1;
   assign h1 = head + TAG_WIDTH'(1);
   assign t1 = tail + TAG_WIDTH'(1);
   assign alloc_ready = count <= CMAX;
   assign alloc_0_tag = tail;
   assign alloc_1_tag = t1;
   assign a0 = alloc_ready & alloc_0_valid & ~flush;
   assign a1 = a0 & alloc_1_valid;
`ifdef ROB_WB_BYPASS_EN
   // A not-yet-ready candidate hit by a bus this cycle takes that bus's data.
   logic m00, m01, m10, m11;
   always_comb begin
      m00 = wb_0_valid & (wb_0_tag == head) & ~ready[head];
      m01 = wb_1_valid & (wb_1_tag == head) & ~ready[head];
      m10 = wb_0_valid & (wb_0_tag == h1) & ~ready[h1];
      m11 = wb_1_valid & (wb_1_tag == h1) & ~ready[h1];
      b0  = m00 | m01;
      b1  = m10 | m11;
      d0  = m00 ? wb_0_data : m01 ? wb_1_data : data_q[head];
      d1  = m10 ? wb_0_data : m11 ? wb_1_data : data_q[h1];
   end
`else
   assign b0 = 1'b0;
   assign b1 = 1'b0;
   assign d0 = data_q[head];
   assign d1 = data_q[h1];
`endif
   assign commit_0_retire = ~flush & valid[head] & (ready[head] | b0);
   assign commit_1_retire = commit_0_retire & valid[h1] & (ready[h1] | b1);
   assign commit_0_we   = commit_0_retire & has_rd[head] & (rd_q[head] != '0);
   assign commit_1_we   = commit_1_retire & has_rd[h1] & (rd_q[h1] != '0);
   assign commit_0_addr = rd_q[head];
   assign commit_1_addr = rd_q[h1];
   assign commit_0_data = d0;
   assign commit_1_data = d1;
   assign commit_0_tag  = head;
   assign commit_1_tag  = h1;
   assign na = (TAG_WIDTH+1)'(a0) + (TAG_WIDTH+1)'(a1);
   assign nr = (TAG_WIDTH+1)'(commit_0_retire) + (TAG_WIDTH+1)'(commit_1_retire);
   assign rob_count = count;
   assign rob_empty = count == '0;
   // Retire clears come after writeback so a bypassed head entry ends up free.
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
         valid <= '0;
         ready <= '0;
      end else begin
         if (wb_0_valid && valid[wb_0_tag]) begin
            ready[wb_0_tag]  <= 1'b1;
            data_q[wb_0_tag] <= wb_0_data;
         end
         if (wb_1_valid && valid[wb_1_tag]) begin
            ready[wb_1_tag]  <= 1'b1;
            data_q[wb_1_tag] <= wb_1_data;
         end
         if (commit_0_retire) begin
            valid[head] <= 1'b0;
            ready[head] <= 1'b0;
         end
         if (commit_1_retire) begin
            valid[h1] <= 1'b0;
            ready[h1] <= 1'b0;
         end
         if (a0) begin
            valid[tail]  <= 1'b1;
            ready[tail]  <= 1'b0;
            has_rd[tail] <= alloc_0_has_rd;
            rd_q[tail]   <= alloc_0_rd;
         end
         if (a1) begin
            valid[t1]  <= 1'b1;
            ready[t1]  <= 1'b0;
            has_rd[t1] <= alloc_1_has_rd;
            rd_q[t1]   <= alloc_1_rd;
         end
         head  <= head + TAG_WIDTH'(commit_0_retire) + TAG_WIDTH'(commit_1_retire);
         tail  <= tail + TAG_WIDTH'(a0) + TAG_WIDTH'(a1);
         count <= count + na - nr;
      end
   end
endmodule

// File: tb/tb_rob_commit.sv
// tb_rob_commit: scoreboard bench for rob_commit; expected commits are queued
// with the cycle they must appear in, and a negedge monitor pops and compares.
module tb_rob_commit;
   logic        clk = 1'b0, rst = 1'b1, flush;
   logic        alloc_0_valid, alloc_1_valid, alloc_0_has_rd, alloc_1_has_rd;
   logic [4:0]  alloc_0_rd, alloc_1_rd, alloc_0_tag, alloc_1_tag;
   logic        alloc_ready;
   logic        wb_0_valid, wb_1_valid;
   logic [4:0]  wb_0_tag, wb_1_tag;
   logic [31:0] wb_0_data, wb_1_data;
   logic        commit_0_retire, commit_1_retire, commit_0_we, commit_1_we;
   logic [4:0]  commit_0_addr, commit_1_addr, commit_0_tag, commit_1_tag;
   logic [31:0] commit_0_data, commit_1_data;
   logic [5:0]  rob_count;
   logic        rob_empty;
`ifdef ROB_WB_BYPASS_EN
   localparam int LAT = 0;
`else
   localparam int LAT = 1;
`endif
   typedef struct {
      int          slot;
      logic        we;
      logic [4:0]  addr;
      logic [31:0] data;
      logic [4:0]  tag;
      int          cyc;
   } exp_t;
   exp_t q[$];
   int chk = 0, err = 0, cyc = 0;
   rob_commit dut (
      .clk(clk), .rst(rst), .flush(flush),
      .alloc_0_valid(alloc_0_valid), .alloc_1_valid(alloc_1_valid),
      .alloc_0_has_rd(alloc_0_has_rd), .alloc_1_has_rd(alloc_1_has_rd),
      .alloc_0_rd(alloc_0_rd), .alloc_1_rd(alloc_1_rd),
      .alloc_ready(alloc_ready), .alloc_0_tag(alloc_0_tag), .alloc_1_tag(alloc_1_tag),
      .wb_0_valid(wb_0_valid), .wb_1_valid(wb_1_valid),
      .wb_0_tag(wb_0_tag), .wb_1_tag(wb_1_tag),
      .wb_0_data(wb_0_data), .wb_1_data(wb_1_data),
      .commit_0_retire(commit_0_retire), .commit_1_retire(commit_1_retire),
      .commit_0_we(commit_0_we), .commit_1_we(commit_1_we),
      .commit_0_addr(commit_0_addr), .commit_1_addr(commit_1_addr),
      .commit_0_data(commit_0_data), .commit_1_data(commit_1_data),
      .commit_0_tag(commit_0_tag), .commit_1_tag(commit_1_tag),
      .rob_count(rob_count), .rob_empty(rob_empty)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic check(input string n, input logic [63:0] a, input logic [63:0] e);
      chk++;
      if (a !== e) begin
         err++;
         $display("FAIL %s got %0h expected %0h (cycle %0d)", n, a, e, cyc);
      end
   endtask
   task automatic pop(input int s, input logic we, input logic [4:0] a,
                      input logic [31:0] d, input logic [4:0] t);
      exp_t e;
      if (q.size() == 0) begin
         chk++;
         err++;
         $display("FAIL unexpected_retire slot %0d tag %0d cycle %0d", s, t, cyc);
      end else begin
         e = q.pop_front();
         check("slot", 64'(s), 64'(e.slot));
         check("we", 64'(we), 64'(e.we));
         check("addr", 64'(a), 64'(e.addr));
         check("data", 64'(d), 64'(e.data));
         check("tag", 64'(t), 64'(e.tag));
         check("cycle", 64'(cyc), 64'(e.cyc));
      end
   endtask
   always @(negedge clk) begin
      if (!rst) begin
         check("we0_without_retire", 64'(commit_0_we & ~commit_0_retire), 64'd0);
         check("we1_without_retire", 64'(commit_1_we & ~commit_1_retire), 64'd0);
         if (commit_0_retire) pop(0, commit_0_we, commit_0_addr, commit_0_data, commit_0_tag);
         if (commit_1_retire) pop(1, commit_1_we, commit_1_addr, commit_1_data, commit_1_tag);
      end
   end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic idle();
      flush = 0;
      alloc_0_valid = 0; alloc_1_valid = 0; alloc_0_has_rd = 0; alloc_1_has_rd = 0;
      alloc_0_rd = 0; alloc_1_rd = 0;
      wb_0_valid = 0; wb_1_valid = 0; wb_0_tag = 0; wb_1_tag = 0; wb_0_data = 0; wb_1_data = 0;
   endtask
   task automatic alloc(input logic v1, input logic h0, input logic [4:0] r0,
                        input logic h1, input logic [4:0] r1);
      alloc_0_valid = 1; alloc_1_valid = v1;
      alloc_0_has_rd = h0; alloc_0_rd = r0; alloc_1_has_rd = h1; alloc_1_rd = r1;
      tick();
      idle();
   endtask
   task automatic wb(input logic v0, input logic [4:0] t0, input logic [31:0] d0,
                     input logic v1, input logic [4:0] t1, input logic [31:0] d1);
      wb_0_valid = v0; wb_0_tag = t0; wb_0_data = d0;
      wb_1_valid = v1; wb_1_tag = t1; wb_1_data = d1;
      tick();
      idle();
   endtask
   task automatic expect_c(input int s, input logic we, input logic [4:0] a,
                           input logic [31:0] d, input logic [4:0] t);
      q.push_back('{slot: s, we: we, addr: a, data: d, tag: t, cyc: cyc + LAT});
   endtask
   initial begin
      idle();
      repeat (2) tick();
      rst = 0;
      check("reset_alloc_ready", 64'(alloc_ready), 64'd1);
      check("reset_tag0", 64'(alloc_0_tag), 64'd0);
      check("reset_tag1", 64'(alloc_1_tag), 64'd1);
      check("reset_empty", 64'(rob_empty), 64'd1);
      check("reset_count", 64'(rob_count), 64'd0);
      repeat (3) tick();
      alloc(1, 1, 5'd5, 1, 5'd6);
      check("dual_alloc_count", 64'(rob_count), 64'd2);
      check("dual_alloc_next_tag", 64'(alloc_0_tag), 64'd2);
      wb(1, 5'd1, 32'hBB, 0, 5'd0, 32'h0);
      expect_c(0, 1, 5'd5, 32'hAA, 5'd0);
      expect_c(1, 1, 5'd6, 32'hBB, 5'd1);
      wb(1, 5'd0, 32'hAA, 0, 5'd0, 32'h0);
      repeat (LAT) tick();
      check("dual_retire_count", 64'(rob_count), 64'd0);
      check("dual_retire_queue", 64'(q.size()), 64'd0);
      alloc(1, 1, 5'd0, 0, 5'd7);
      check("nowrite_alloc_count", 64'(rob_count), 64'd2);
      expect_c(0, 0, 5'd0, 32'h11, 5'd2);
      expect_c(1, 0, 5'd7, 32'h22, 5'd3);
      wb(1, 5'd2, 32'h11, 1, 5'd3, 32'h22);
      repeat (LAT) tick();
      check("nowrite_count", 64'(rob_count), 64'd0);
      for (int k = 0; k < 15; k++) begin
         logic [4:0] et;
         et = 5'(4 + 2 * k);
         check("fill_tag0", 64'(alloc_0_tag), 64'(et));
         check("fill_tag1", 64'(alloc_1_tag), 64'(5'(et + 5'd1)));
         alloc(1, 1, et, 1, 5'(et + 5'd1));
      end
      check("fill30_count", 64'(rob_count), 64'd30);
      check("fill30_ready", 64'(alloc_ready), 64'd1);
      alloc(0, 1, 5'd2, 0, 5'd0);
      check("fill31_count", 64'(rob_count), 64'd31);
      check("fill31_ready", 64'(alloc_ready), 64'd0);
      check("fill31_tag", 64'(alloc_0_tag), 64'd3);
      alloc(1, 1, 5'd9, 1, 5'd9);
      check("dropped_alloc_count", 64'(rob_count), 64'd31);
      check("dropped_alloc_tag", 64'(alloc_0_tag), 64'd3);
      expect_c(0, 1, 5'd4, 32'h104, 5'd4);
      wb(1, 5'd4, 32'h104, 0, 5'd0, 32'h0);
      repeat (LAT) tick();
      check("free_one_count", 64'(rob_count), 64'd30);
      check("free_one_ready", 64'(alloc_ready), 64'd1);
      for (int k = 6; k < 16; k += 2)
         wb(1, 5'(k), 32'(k), 1, 5'(k + 1), 32'(k + 1));
      check("ten_ready_count", 64'(rob_count), 64'd30);
      flush = 1; alloc_0_valid = 1; alloc_0_has_rd = 1; alloc_0_rd = 5'd3;
      wb_0_valid = 1; wb_0_tag = 5'd5; wb_0_data = 32'h5;
      tick();
      idle();
      check("flush_count", 64'(rob_count), 64'd0);
      check("flush_empty", 64'(rob_empty), 64'd1);
      check("flush_tag0", 64'(alloc_0_tag), 64'd0);
      check("flush_ready", 64'(alloc_ready), 64'd1);
      repeat (2) tick();
      alloc(0, 1, 5'd9, 0, 5'd0);
      expect_c(0, 1, 5'd9, 32'h55, 5'd0);
      wb(1, 5'd0, 32'h55, 0, 5'd0, 32'h0);
      repeat (LAT) tick();
      check("post_flush_count", 64'(rob_count), 64'd0);
      alloc(1, 1, 5'd1, 1, 5'd2);
      check("pre_reset_count", 64'(rob_count), 64'd2);
      rst = 1; flush = 1;
      tick();
      rst = 0; flush = 0;
      check("midreset_count", 64'(rob_count), 64'd0);
      check("midreset_tag0", 64'(alloc_0_tag), 64'd0);
      check("midreset_tag1", 64'(alloc_1_tag), 64'd1);
      check("midreset_empty", 64'(rob_empty), 64'd1);
      wb(1, 5'd1, 32'hDEAD, 0, 5'd0, 32'h0);
      repeat (2) tick();
      check("final_queue_empty", 64'(q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", chk, err);
      $finish;
   end
endmodule

// File: doc/rob_commit.md
# rob_commit

In-order reorder buffer and retirement engine for the dual-issue rename/commit pipeline. It allocates up to two entries per cycle at rename and hands each new instruction its tag. It captures results from two writeback buses and retires up to two completed instructions per cycle, in program order. Its commit outputs feed the register file's two commit data-write ports; the register file uses the tag in each commit to clear the renamed bit.

## Interface
- ROB_DEPTH, 32: entry count; power of two, ≥4.
- TAG_WIDTH, $clog2(ROB_DEPTH): tag = entry index.
- DATA_W, 32: result width (CPU_DATA_BITS).
- AREG_W, 5: architectural register index width.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  squash all entries.
- alloc_0_valid, alloc_1_valid  in  1  allocation requests, slot 0 older.
- alloc_0_has_rd, alloc_1_has_rd  in  1  instruction writes a destination register.
- alloc_0_rd, alloc_1_rd  in  AREG_W  destination register.
- alloc_ready  out  1  at least two free entries.
- alloc_0_tag, alloc_1_tag  out  TAG_WIDTH  tail and tail+1 (mod ROB_DEPTH).
- wb_0_valid, wb_1_valid  in  1  writeback strobes.
- wb_0_tag, wb_1_tag  in  TAG_WIDTH  completing entry.
- wb_0_data, wb_1_data  in  DATA_W  result.
- commit_0_retire, commit_1_retire  out  1  entry retires this cycle.
- commit_0_we, commit_1_we  out  1  register write enable.
- commit_0_addr, commit_1_addr  out  AREG_W  destination.
- commit_0_data, commit_1_data  out  DATA_W  result.
- commit_0_tag, commit_1_tag  out  TAG_WIDTH  retiring entry's tag.
- rob_count  out  TAG_WIDTH+1  occupied entries.
- rob_empty  out  1  rob_count == 0.

## Operation
- State: head and tail pointers (TAG_WIDTH bits, wrap naturally), count, and per-entry valid, ready, has_rd, rd, data.
- Allocation:
  - Fires when alloc_ready is high and alloc_0_valid is high. alloc_1 fires only together with alloc_0.
  - alloc_1_valid without alloc_0_valid is illegal and is ignored.
  - A new entry is written valid=1, ready=0. tail advances by 0, 1 or 2.
  - alloc_Nvalid while alloc_ready=0 is dropped; rename must stall.
- Writeback:
  - wb_N_valid sets ready and stores data in entry wb_N_tag.
  - Writeback to an invalid entry is ignored.
  - Both buses hitting the same tag is illegal.
- Retire:
  - commit_0_retire = valid[head] & ready[head].
  - commit_1_retire = commit_0_retire & valid[head+1] & ready[head+1].
  - A retiring entry is cleared. head advances by the number retired.
- commit_N_we = commit_N_retire & has_rd & (rd != 0).
- addr, data and tag always reflect the candidate entry. They are don't-care when retire=0.
- count_next = count + allocs − retires. alloc_ready = (ROB_DEPTH − count) ≥ 2, computed from registered count.
- Flush: on the next edge all valid bits clear, head = tail = count = 0. During the flush cycle, commit_N_retire and commit_N_we are forced to 0, and allocations and writebacks are discarded.
- Allocate, writeback and retire in the same cycle are all legal. A freed slot cannot be reallocated in the same cycle, since alloc_ready uses registered count.
- Retire-then-allocate of the same index across cycles is legal. A stale writeback for the freed tag is illegal upstream.

## Timing
- Reset values: head = tail = count = 0, all entries invalid. alloc_ready=1, alloc_0_tag=0, alloc_1_tag=1. All retire and we outputs 0, rob_count=0, rob_empty=1.
- All outputs are combinational from registered state, plus wb ports when bypass is enabled.
- Allocation in cycle N: entry valid from N+1. The earliest legal writeback is N+1.
- Writeback in cycle N without bypass: commit_we can rise in N+1. The register file updates at the end of N+1.
- Reset asserted mid-operation: the state above is restored on the next edge, with rst taking priority over flush.

## Configuration
- ROB_WB_BYPASS_EN:
  - Defined: an entry not yet ready but matched by wb_N_valid/wb_N_tag in the current cycle counts as ready. commit_N_data then comes from the matching wb_N_data, giving writeback-to-commit in the same cycle.
  - Undefined: readiness comes only from registered ready bits, so retirement happens one cycle after writeback.

## Test plan
- Reset: after rst, alloc_ready=1, alloc tags 0/1, rob_empty=1, no retire for 3 cycles.
- Dual allocate rd=5 and rd=6 (tags 0, 1); wb tag1=0xBB in cycle 2, then tag0=0xAA in cycle 3 → nothing retires until cycle 4 (bypass off). In cycle 4 both retire together: commit_0 {5, 0xAA, tag 0} and commit_1 {6, 0xBB, tag 1}.
- rd=0 and has_rd=0 entries complete → retire=1, we=0; count decrements.
- Fill to ROB_DEPTH−1 → alloc_ready=0. Retire one entry → alloc_ready=1 next cycle. Tags wrap from 31 to 0 correctly.
- Flush with 10 ready entries → no retire in the flush cycle. Next cycle count=0 and alloc_0_tag=0.
- With ROB_WB_BYPASS_EN defined: single entry, writeback 0x1234 in cycle N → commit_0_we=1 with data 0x1234 in cycle N.
